// File: rtl/ex_mem_stage_pkg.sv
// Shared core definitions: ALU opcodes, branch funct3 codes and the EX/MEM control bundle.
// Branch codes follow the RV32I B-type funct3 encoding.
package ex_mem_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// Branch condition from ALU subtract flags (a - b); zero latency, purely combinational.
// cf=1 means a >= b unsigned (no borrow); reserved funct3 codes are never taken.
module branch_cond
  import ex_mem_stage_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       cf,
  input  logic       zf,
  input  logic       vf,
  input  logic       sf,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      BR_BEQ:  cond = zf;
      BR_BNE:  cond = !zf;
      BR_BLT:  cond = (sf != vf);
      BR_BGE:  cond = (sf == vf);
      BR_BLTU: cond = !cf;
      BR_BGEU: cond = cf;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution; 1-cycle latency, redirect registered.
// stall freezes everything (a flush seen during stall is remembered); taken redirects self-squash the next capture.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_r,
  input  logic            ex_cf,
  input  logic            ex_zf,
  input  logic            ex_vf,
  input  logic            ex_sf,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic            ex_memwrite,
  input  logic            ex_memtoreg,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_pc4,
  input  logic            stall,
  input  logic            flush,
  output logic            mem_valid,
  output logic            mem_regwrite,
  output logic            mem_memread,
  output logic            mem_memwrite,
  output logic            mem_memtoreg,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_rs2,
  output logic [RA_W-1:0] mem_rd,
  output logic [2:0]      mem_funct3,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  logic            cond;
  logic            taken;
  logic            kill;

  logic            valid_q,      valid_d;
  ctrl_t           ctrl_q,       ctrl_d;
  logic [XLEN-1:0] result_q,     result_d;
  logic [XLEN-1:0] rs2_q,        rs2_d;
  logic [RA_W-1:0] rd_q,         rd_d;
  logic [2:0]      funct3_q,     funct3_d;
  logic            taken_q,      taken_d;
  logic [XLEN-1:0] target_q,     target_d;
  logic            flush_pend_q, flush_pend_d;
  logic            squash_q,     squash_d;

  branch_cond u_branch_cond (
    .funct3 (ex_funct3),
    .cf     (ex_cf),
    .zf     (ex_zf),
    .vf     (ex_vf),
    .sf     (ex_sf),
    .cond   (cond)
  );

  assign taken = (ex_branch & cond) | ex_jump;
  assign kill  = flush | flush_pend_q | squash_q;

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    result_d     = result_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    funct3_d     = funct3_q;
    taken_d      = taken_q;
    target_d     = target_q;
    flush_pend_d = flush_pend_q;
    squash_d     = squash_q;

    if (!stall) begin
      valid_d         = ex_valid & !kill;
      ctrl_d.regwrite = ex_regwrite & !kill;
      ctrl_d.memread  = ex_memread & !kill;
      ctrl_d.memwrite = ex_memwrite & !kill;
      ctrl_d.memtoreg = ex_memtoreg;
      taken_d         = taken & !kill;
      result_d        = ex_jump ? ex_pc4 : ex_alu_r;
      rs2_d           = ex_rs2;
      rd_d            = ex_rd;
      funct3_d        = ex_funct3;
      target_d        = ex_target;
      flush_pend_d    = 1'b0;
      // Whatever EX holds next cycle was fetched down the wrong path.
      squash_d        = valid_d & taken;
    end else if (flush) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      result_q     <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct3_q     <= '0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      flush_pend_q <= 1'b0;
      squash_q     <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      result_q     <= result_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      flush_pend_q <= flush_pend_d;
      squash_q     <= squash_d;
    end
  end

  assign mem_valid    = valid_q;
  assign mem_regwrite = ctrl_q.regwrite;
  assign mem_memread  = ctrl_q.memread;
  assign mem_memwrite = ctrl_q.memwrite;
  assign mem_memtoreg = ctrl_q.memtoreg;
  assign mem_result   = result_q;
  assign mem_rs2      = rs2_q;
  assign mem_rd       = rd_q;
  assign mem_funct3   = funct3_q;
  assign redirect     = valid_q & taken_q;
  assign redirect_pc  = target_q;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage of the pipelined RV32I core. Sits directly downstream of the 32-bit ALU.
- Captures the ALU result, the ALU flags (cf, zf, vf, sf) and the EX control bundle.
- Resolves conditional branches and jumps from the flags and issues a registered PC redirect.
- Provides stall-hold, flush/bubble insertion with a pending-flush memory, and self-squash of the wrong-path instruction following a taken redirect.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX holds a real instruction.
- ex_alu_r  in  XLEN  ALU result.
- ex_cf, ex_zf, ex_vf, ex_sf  in  1 each  ALU flags from the subtract path.
- ex_rs2  in  XLEN  store data.
- ex_rd  in  RA_W  destination register.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  in  1 each  control bits.
- ex_branch  in  1  conditional branch.
- ex_jump  in  1  JAL/JALR.
- ex_funct3  in  3  branch condition / memory size.
- ex_target  in  XLEN  branch/jump target, precomputed in EX.
- ex_pc4  in  XLEN  PC+4.
- stall  in  1  MEM busy; hold all state.
- flush  in  1  hazard unit requests a bubble.
- mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg  out  1 each  registered.
- mem_result  out  XLEN  registered writeback/address value.
- mem_rs2  out  XLEN  registered store data.
- mem_rd  out  RA_W  registered destination register.
- mem_funct3  out  3  registered funct3.
- redirect  out  1  taken branch/jump is in MEM.
- redirect_pc  out  XLEN  registered target.

Behaviour:
- Reset: every registered output is 0, flush_pend is 0, squash is 0. Reset wins over stall and flush.
- Latency: 1 cycle from EX inputs to mem_* outputs. redirect is combinational from registered state (mem_valid & taken_q), so it is asserted in the cycle after capture.
- Branch condition, evaluated in EX from the flags:
  - BEQ 000: zf.
  - BNE 001: !zf.
  - BLT 100: sf!=vf.
  - BGE 101: sf==vf.
  - BLTU 110: !cf.
  - BGEU 111: cf.
  - 010 and 011: not taken.
- taken = ex_branch & cond | ex_jump.
- mem_result = ex_jump ? ex_pc4 : ex_alu_r.
- Capture enable: cap = !stall. When cap is high:
  - kill = flush | flush_pend | squash.
  - mem_valid <= ex_valid & !kill.
  - When the capture is killed: regwrite, memread, memwrite and taken_q are cleared; data fields may load but are don't-care.
  - flush_pend <= 0.
  - squash <= next_valid & taken, where next_valid is the value being written to mem_valid.
- stall high: all registers hold; redirect stays asserted if already asserted. A flush arriving during a stall sets flush_pend <= 1, so the bubble is inserted at the next non-stalled capture.
- Self-squash: the instruction captured in the cycle after a taken instruction enters MEM is wrong-path and is killed. The hazard unit need not drive flush for this case.
- Simultaneous events:
  - flush plus a valid taken branch in EX: flush kills it and no redirect occurs.
  - stall plus flush: hold, and flush is recorded in flush_pend.
- Flags only matter when ex_branch is set; cf follows the borrow-free convention (cf=1 means a>=b unsigned).

Decomposition:
- Branch funct3 codes BR_BEQ through BR_BGEU go in the shared defines header, alongside the ALU opcodes.
- One combinational sub-module, branch_cond(funct3, cf, zf, vf, sf) -> cond, reused by any later early-branch logic.

Test Plan:
- BEQ, a=5, b=5: ALU gives zf=1, ex_target=0x100. Next cycle redirect=1 and redirect_pc=0x100. The following capture has ex_valid=1 but mem_valid=0 (self-squash).
- BLT, a=0xFFFFFFFF, b=1: sf=1, vf=0, so taken. BLTU with the same operands: cf=1, not taken, redirect=0.
- JAL: ex_pc4=0x24, ex_alu_r=0xDEAD. Required: mem_result=0x24, mem_regwrite=1, redirect=1.
- stall held 3 cycles with flush pulsed in cycle 2: mem_* outputs are unchanged for all 3 cycles. The first capture after stall deasserts gives mem_valid=0; the one after that gives mem_valid=1.
- rst asserted while mem_valid=1 and redirect=1, with stall=1: the next cycle has all outputs 0 and redirect=0.
- SW: ex_rs2=0x12345678, ex_alu_r=0x1000 (address). Required: mem_memwrite=1, mem_result=0x1000, mem_rs2=0x12345678, mem_regwrite=0.
